// File: rtl/nlc_pkg.sv
// Shared definitions for the round-robin linearizer scheduler:
// sample width, FSM state encoding and parameter defaults.
package nlc_pkg;

    localparam int SAMPLE_W    = 21;
    localparam int DEF_NCH     = 4;
    localparam int DEF_TIMEOUT = 300;
    localparam int DEF_GAP     = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_OUT   = 3'd3,
        ST_GUARD = 3'd4
    } nlc_state_t;

    // Channel index following v, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        if (v + 1 >= n)
            return 0;
        return v + 1;
    endfunction

endpackage

// File: rtl/nlc_rr_pick.sv
// Rotating priority encoder: first set bit of pend searching upward from
// rr_ptr with wrap-around.
module nlc_rr_pick
    import nlc_pkg::*;
#(
    parameter int NCH = DEF_NCH,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] pend,
    input  logic [CW-1:0]  rr_ptr,
    output logic [CW-1:0]  grant,
    output logic           any
);

    logic [CW-1:0] sel;

    // Walk from the farthest offset down to rr_ptr so the closest request wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        sel   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            sel = CW'((int'(rr_ptr) + k) % NCH);
            if (pend[sel]) begin
                grant = sel;
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nlc_rr_sched.sv
// Round-robin scheduler sharing one linearizer core between NCH ADC channels,
// with per-channel sample holding, overrun flags and a core watchdog.
module nlc_rr_sched
    import nlc_pkg::*;
#(
    parameter int NCH     = DEF_NCH,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int GAP     = DEF_GAP
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          ch_valid,
    input  logic [SAMPLE_W*NCH-1:0] ch_x,
    output logic                    core_reset,
    output logic                    core_srdyi,
    output logic [SAMPLE_W-1:0]     core_x_adc,
    input  logic                    core_srdyo,
    input  logic [SAMPLE_W-1:0]     core_x_lin,
    output logic                    out_valid,
    output logic [1:0]              out_ch,
    output logic [SAMPLE_W-1:0]     out_x_lin,
    output logic [NCH-1:0]          overrun,
    output logic                    timeout_err,
    output logic                    busy
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    nlc_state_t          state;
    logic [NCH-1:0]      pend;
    logic [SAMPLE_W-1:0] hold [NCH];
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       g;
    logic [TW-1:0]       timer;
    logic [GW-1:0]       gap_cnt;
    logic                abort_q;

    logic [CW-1:0]       pick_idx;
    logic                pick_any;
    logic                grant_now;
    logic [CW-1:0]       next_ptr;

    nlc_rr_pick #(
        .NCH (NCH),
        .CW  (CW)
    ) u_pick (
        .pend   (pend),
        .rr_ptr (rr_ptr),
        .grant  (pick_idx),
        .any    (pick_any)
    );

    assign grant_now  = (state == ST_IDLE) && pick_any;
    assign next_ptr   = CW'(wrap_inc(32'(g), 32'(NCH)));
    assign busy       = (state != ST_IDLE);
    assign core_reset = reset | abort_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pend        <= '0;
            overrun     <= '0;
            rr_ptr      <= '0;
            g           <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            abort_q     <= 1'b0;
            core_srdyi  <= 1'b0;
            core_x_adc  <= '0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_x_lin   <= '0;
            timeout_err <= 1'b0;
            for (int i = 0; i < NCH; i++)
                hold[i] <= '0;
        end else begin
            core_srdyi  <= 1'b0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
            abort_q     <= 1'b0;

            // A strobe on the channel being granted this cycle is not an overrun:
            // the old sample goes to the core and the new one stays pending.
            for (int i = 0; i < NCH; i++) begin
                if (ch_valid[i]) begin
                    hold[i] <= ch_x[i*SAMPLE_W +: SAMPLE_W];
                    pend[i] <= 1'b1;
                    if (pend[i] && !(grant_now && int'(pick_idx) == i))
                        overrun[i] <= 1'b1;
                end else if (grant_now && int'(pick_idx) == i) begin
                    pend[i] <= 1'b0;
                end
            end

            unique case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        g          <= pick_idx;
                        core_srdyi <= 1'b1;
                        core_x_adc <= hold[pick_idx];
                        state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_srdyo) begin
                        out_x_lin <= core_x_lin;
                        out_ch    <= 2'(g);
                        out_valid <= 1'b1;
                        state     <= ST_OUT;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        abort_q     <= 1'b1;
                        timeout_err <= 1'b1;
                        rr_ptr      <= next_ptr;
                        gap_cnt     <= '0;
                        state       <= ST_GUARD;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_OUT: begin
                    rr_ptr  <= next_ptr;
                    gap_cnt <= '0;
                    state   <= ST_GUARD;
                end
                ST_GUARD: begin
                    if (GAP <= 1 || gap_cnt == GW'(GAP - 1))
                        state <= ST_IDLE;
                    else
                        gap_cnt <= gap_cnt + GW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nlc_rr_sched.sv
// Directed bench for nlc_rr_sched: single-request vector table plus
// hand-written sequences for round-robin order, overrun, timeout and reset.
module tb_nlc_rr_sched;

    localparam int NCH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    ch_valid;
    logic [83:0]   ch_x;
    logic          core_reset;
    logic          core_srdyi;
    logic [20:0]   core_x_adc;
    logic          core_srdyo;
    logic [20:0]   core_x_lin;
    logic          out_valid;
    logic [1:0]    out_ch;
    logic [20:0]   out_x_lin;
    logic [3:0]    overrun;
    logic          timeout_err;
    logic          busy;

    int tests_run    = 0;
    int tests_failed = 0;
    int ov_count     = 0;

    typedef struct {
        logic [1:0]  ch;
        logic [20:0] x;
        logic [20:0] res;
        int          delay;
    } vec_t;

    vec_t vecs[4];

    nlc_rr_sched #(
        .NCH     (NCH),
        .TIMEOUT (300),
        .GAP     (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ch_valid    (ch_valid),
        .ch_x        (ch_x),
        .core_reset  (core_reset),
        .core_srdyi  (core_srdyi),
        .core_x_adc  (core_x_adc),
        .core_srdyo  (core_srdyo),
        .core_x_lin  (core_x_lin),
        .out_valid   (out_valid),
        .out_ch      (out_ch),
        .out_x_lin   (out_x_lin),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (out_valid === 1'b1)
            ov_count++;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task tick();
        @(posedge clk);
        #1;
    endtask

    task checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [83:0] packX(input int ch, input logic [20:0] x);
        logic [83:0] v;
        v = '0;
        v[ch*21 +: 21] = x;
        return v;
    endfunction

    task applyStimulus(input logic [3:0] valid, input logic [83:0] xs);
        ch_valid = valid;
        ch_x     = xs;
        tick();
        ch_valid = '0;
    endtask

    task doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task waitIdle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!busy)
                break;
            tick();
        end
        checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    task waitSrdyi(output bit found);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (core_srdyi) begin
                found = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Called with the DUT in WAIT; the core model answers after 'delay' more cycles.
    task respond(input string tag, input logic [1:0] exp_ch, input logic [20:0] res, input int delay);
        repeat (delay) tick();
        core_srdyo = 1'b1;
        core_x_lin = res;
        tick();
        core_srdyo = 1'b0;
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, "_out_ch"}, 32'(out_ch), 32'(exp_ch));
        checkOutput({tag, "_out_x_lin"}, 32'(out_x_lin), 32'(res));
        tick();
        checkOutput({tag, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    task serveOne(input string tag, input logic [20:0] exp_x, input logic [1:0] exp_ch,
                  input logic [20:0] res, input int delay);
        bit found;
        waitSrdyi(found);
        checkOutput({tag, "_srdyi_seen"}, 32'(found), 32'd1);
        checkOutput({tag, "_core_x_adc"}, 32'(core_x_adc), 32'(exp_x));
        tick();
        checkOutput({tag, "_srdyi_one_cycle"}, 32'(core_srdyi), 32'd0);
        respond(tag, exp_ch, res, delay);
    endtask

    initial begin
        int ov0;

        reset      = 1'b1;
        ch_valid   = '0;
        ch_x       = '0;
        core_srdyo = 1'b0;
        core_x_lin = '0;

        vecs[0] = '{ch: 2'd0, x: 21'h00100,  res: 21'h0ABCD,  delay: 200};
        vecs[1] = '{ch: 2'd3, x: 21'h1FFFFF, res: 21'h100000, delay: 0};
        vecs[2] = '{ch: 2'd1, x: 21'h0FFFFF, res: 21'h1FFFFF, delay: 5};
        vecs[3] = '{ch: 2'd2, x: 21'h12345,  res: 21'h054321, delay: 299};

        tick();
        tick();
        checkOutput("rst_core_reset", 32'(core_reset), 32'd1);
        checkOutput("rst_core_srdyi", 32'(core_srdyi), 32'd0);
        checkOutput("rst_core_x_adc", 32'(core_x_adc), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_ch", 32'(out_ch), 32'd0);
        checkOutput("rst_out_x_lin", 32'(out_x_lin), 32'd0);
        checkOutput("rst_overrun", 32'(overrun), 32'd0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("rst_release_core_reset", 32'(core_reset), 32'd0);

        // Single requests, each with the exact two-cycle issue latency.
        for (int i = 0; i < 4; i++) begin
            waitIdle($sformatf("vec%0d", i));
            applyStimulus(4'(1 << vecs[i].ch), packX(int'(vecs[i].ch), vecs[i].x));
            checkOutput($sformatf("vec%0d_srdyi_t1", i), 32'(core_srdyi), 32'd0);
            tick();
            checkOutput($sformatf("vec%0d_srdyi_t2", i), 32'(core_srdyi), 32'd1);
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'd1);
            serveOne($sformatf("vec%0d", i), vecs[i].x, vecs[i].ch, vecs[i].res, vecs[i].delay);
        end
        checkOutput("vec_no_overrun", 32'(overrun), 32'd0);

        // Round-robin order from reset, then from a moved pointer.
        waitIdle("rr");
        doReset();
        applyStimulus(4'b1111, {21'h01003, 21'h01002, 21'h01001, 21'h01000});
        for (int c = 0; c < 4; c++)
            serveOne($sformatf("rr1_%0d", c), 21'(32'h01000 + c), 2'(c), 21'(32'h02000 + c), 1);
        waitIdle("rr_pre");
        applyStimulus(4'b0010, packX(1, 21'h00111));
        serveOne("rr_pre", 21'h00111, 2'd1, 21'h00222, 0);
        waitIdle("rr2");
        applyStimulus(4'b1111, {21'h03003, 21'h03002, 21'h03001, 21'h03000});
        for (int c = 0; c < 4; c++)
            serveOne($sformatf("rr2_%0d", c), 21'(32'h03000 + ((c + 2) % 4)), 2'((c + 2) % 4),
                     21'(32'h04000 + c), 2);
        checkOutput("rr_no_overrun", 32'(overrun), 32'd0);

        // Overrun: channel 2 strobed twice while the core serves channel 0.
        waitIdle("ovr");
        doReset();
        applyStimulus(4'b0001, packX(0, 21'h00ABC));
        tick();
        checkOutput("ovr_c0_srdyi", 32'(core_srdyi), 32'd1);
        checkOutput("ovr_c0_x_adc", 32'(core_x_adc), 32'h00ABC);
        applyStimulus(4'b0100, packX(2, 21'h11111));
        checkOutput("ovr_first_strobe", 32'(overrun), 32'd0);
        applyStimulus(4'b0100, packX(2, 21'h02222));
        checkOutput("ovr_set", 32'(overrun), 32'b0100);
        respond("ovr_c0", 2'd0, 21'h00001, 2);
        serveOne("ovr_c2", 21'h02222, 2'd2, 21'h00002, 1);
        checkOutput("ovr_sticky", 32'(overrun), 32'b0100);

        // Core never answers channel 1; channel 3 must follow after the guard.
        waitIdle("tmo");
        doReset();
        checkOutput("tmo_overrun_cleared", 32'(overrun), 32'd0);
        applyStimulus(4'b1010, packX(1, 21'h00C01) | packX(3, 21'h00C03));
        tick();
        checkOutput("tmo_c1_srdyi", 32'(core_srdyi), 32'd1);
        checkOutput("tmo_c1_x_adc", 32'(core_x_adc), 32'h00C01);
        ov0 = ov_count;
        tick();
        repeat (299) tick();
        checkOutput("tmo_last_wait_err", 32'(timeout_err), 32'd0);
        checkOutput("tmo_last_wait_busy", 32'(busy), 32'd1);
        tick();
        checkOutput("tmo_err_pulse", 32'(timeout_err), 32'd1);
        checkOutput("tmo_core_reset_pulse", 32'(core_reset), 32'd1);
        checkOutput("tmo_no_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("tmo_err_one_cycle", 32'(timeout_err), 32'd0);
        checkOutput("tmo_core_reset_one_cycle", 32'(core_reset), 32'd0);
        checkOutput("tmo_guard_no_srdyi", 32'(core_srdyi), 32'd0);
        tick();
        checkOutput("tmo_idle_busy", 32'(busy), 32'd0);
        checkOutput("tmo_idle_no_srdyi", 32'(core_srdyi), 32'd0);
        tick();
        checkOutput("tmo_c3_srdyi", 32'(core_srdyi), 32'd1);
        checkOutput("tmo_c3_x_adc", 32'(core_x_adc), 32'h00C03);
        checkOutput("tmo_no_result_count", 32'(ov_count - ov0), 32'd0);
        tick();
        respond("tmo_c3", 2'd3, 21'h00C33, 3);

        // Reset during WAIT; the late core answer must be ignored.
        waitIdle("rmw");
        applyStimulus(4'b0001, packX(0, 21'h00E00));
        tick();
        checkOutput("rmw_srdyi", 32'(core_srdyi), 32'd1);
        tick();
        tick();
        ov0 = ov_count;
        reset = 1'b1;
        tick();
        checkOutput("rmw_core_reset", 32'(core_reset), 32'd1);
        checkOutput("rmw_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        repeat (4) tick();
        core_srdyo = 1'b1;
        core_x_lin = 21'h0DEAD;
        tick();
        core_srdyo = 1'b0;
        checkOutput("rmw_late_out_valid", 32'(out_valid), 32'd0);
        tick();
        checkOutput("rmw_result_count", 32'(ov_count - ov0), 32'd0);
        checkOutput("rmw_out_ch", 32'(out_ch), 32'd0);
        checkOutput("rmw_out_x_lin", 32'(out_x_lin), 32'd0);
        checkOutput("rmw_core_x_adc", 32'(core_x_adc), 32'd0);
        checkOutput("rmw_core_srdyi", 32'(core_srdyi), 32'd0);
        checkOutput("rmw_timeout_err", 32'(timeout_err), 32'd0);
        checkOutput("rmw_core_reset_low", 32'(core_reset), 32'd0);
        checkOutput("rmw_busy_after", 32'(busy), 32'd0);

        // Strobe on channel 1 in the very cycle it is granted.
        applyStimulus(4'b0010, packX(1, 21'h00AAA));
        applyStimulus(4'b0010, packX(1, 21'h00BBB));
        checkOutput("same_srdyi", 32'(core_srdyi), 32'd1);
        checkOutput("same_old_sample", 32'(core_x_adc), 32'h00AAA);
        checkOutput("same_no_overrun", 32'(overrun), 32'd0);
        tick();
        respond("same_first", 2'd1, 21'h0F0F0, 1);
        serveOne("same_second", 21'h00BBB, 2'd1, 21'h00F0F, 1);
        checkOutput("same_overrun_final", 32'(overrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/nlc_rr_sched.md
NLC_RR_SCHED -- requirements
Module: nlc_rr_sched

Interface
REQ-001 Parameter NCH, default 4: number of ADC channels sharing one linearizer core.
REQ-002 Parameter TIMEOUT, default 300: max cycles in WAIT before abort.
REQ-003 Parameter GAP, default 2: min idle cycles between core_srdyo and next core_srdyi.
REQ-004 clk  in  1  clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 ch_valid  in  NCH  one-cycle sample strobe per channel.
REQ-007 ch_x  in  21*NCH  sfix21 samples; channel i at bits [21i+20:21i].
REQ-008 core_reset  out  1  reset to core; equals reset OR abort pulse.
REQ-009 core_srdyi  out  1  one-cycle start strobe to core.
REQ-010 core_x_adc  out  21  sample presented to core, held stable from core_srdyi until next grant.
REQ-011 core_srdyo  in  1  core result strobe.
REQ-012 core_x_lin  in  21  core result, valid with core_srdyo.
REQ-013 out_valid  out  1  one-cycle result strobe.
REQ-014 out_ch  out  2  channel index of result.
REQ-015 out_x_lin  out  21  linearized result.
REQ-016 overrun  out  NCH  sticky per-channel sample-overwrite flags.
REQ-017 timeout_err  out  1  one-cycle abort indication.
REQ-018 busy  out  1  high in any state except IDLE.

Function
REQ-019 ch_valid[i] captures ch_x slice into hold[i] and sets pend[i] on the next edge.
REQ-020 ch_valid[i] while pend[i]=1 and channel i not granted that cycle: overwrite hold[i], set overrun[i].
REQ-021 ch_valid[i] in the same cycle channel i is granted: granted sample = old hold[i]; new sample held, pend[i] stays 1, no overrun.
REQ-022 FSM states: IDLE, ISSUE, WAIT, OUT, GUARD.
REQ-023 IDLE: any pend set -> grant first pending channel searching upward from rr_ptr with wrap; latch g, clear pend[g], go ISSUE.
REQ-024 ISSUE: core_srdyi=1 and core_x_adc=hold[g] for exactly one cycle; timer<=0; go WAIT.
REQ-025 WAIT: core_srdyo=1 -> register core_x_lin, go OUT; else timer+1; timer==TIMEOUT-1 -> go GUARD with abort.
REQ-026 OUT: out_valid=1, out_ch=g, out_x_lin=latched result, one cycle; rr_ptr<=g+1 mod NCH; go GUARD.
REQ-027 Abort: core_reset=1 and timeout_err=1 for one cycle; no out_valid; rr_ptr<=g+1 mod NCH; sample dropped.
REQ-028 GUARD: hold GAP cycles, then IDLE.
REQ-029 Minimum latency ch_valid (cycle t) -> core_srdyi: cycle t+2 with core idle.
REQ-030 core_srdyo outside WAIT: ignored.
REQ-031 Overrun bits clear only on reset.

Reset
REQ-032 reset: state IDLE, pend=0, overrun=0, rr_ptr=0, timer=0, g=0.
REQ-033 reset outputs: core_srdyi=0, core_x_adc=0, out_valid=0, out_ch=0, out_x_lin=0, timeout_err=0, busy=0; core_reset=1 while reset high.
REQ-034 reset mid-WAIT: in-flight result discarded; late core_srdyo produces no out_valid.

Structure
REQ-035 Shared package nlc_pkg: FSM state encoding, sample width 21, default TIMEOUT/GAP.
REQ-036 One sub-module nlc_rr_pick: combinational rotating priority encoder (pend, rr_ptr -> grant index, any).
REQ-037 Single always block for FSM/registers; no combinational paths input to output.

Verification
REQ-038 Single request: ch_valid=0001, ch_x[20:0]=0x00100 at t -> core_srdyi at t+2 with core_x_adc=0x00100; model core_srdyo 200 cycles later with 0x0ABCD -> out_valid, out_ch=0, out_x_lin=0x0ABCD.
REQ-039 All four channels strobed same cycle -> grant order 0,1,2,3; second round order starts at rr_ptr.
REQ-040 Channel 2 strobed twice while pending (0x11111 then 0x02222) -> overrun=0100, core sees 0x02222.
REQ-041 Core never responds -> after 300 WAIT cycles timeout_err and core_reset pulse 1 cycle, no out_valid, next pending channel issued after GAP.
REQ-042 reset asserted mid-WAIT, core_srdyo arrives 5 cycles later -> no out_valid, all outputs at reset values.
REQ-043 ch_valid on granted channel in IDLE grant cycle -> old sample issued, new sample issued next round, overrun stays 0.
